// File: rtl/master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : master_arbiter
// Description : Two-master, one-slave round-robin arbiter. A registered FSM
//               (IDLE / GNT_M1 / GNT_M2) owns the shared slave channel. The
//               slave request channel and the master response channels are
//               muxed combinationally from the current owner.
//               Optional feature macro: ARB_TIMEOUT_EN. When it is defined,
//               a grant that sees no ack for TIMEOUT cycles is aborted with a
//               one-cycle err pulse to the owning master.
// Ports       : clk, rst                 - clock, sync active-high reset
//               master_{1,2}_req/addr/cmd/wdata - master request channels
//               master_{1,2}_ack/rdata/err      - master response channels
//               slave_req/addr/cmd/wdata        - shared slave request
//               slave_ack/rdata                 - slave response
//               grant                    - one-hot owner (01 = m1, 10 = m2)
// Revision    : 1.0 - initial release
// ============================================================================
module master_arbiter #(
    parameter int N       = 32,
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         master_1_req,
    input  logic [N-1:0] master_1_addr,
    input  logic         master_1_cmd,
    input  logic [N-1:0] master_1_wdata,
    output logic         master_1_ack,
    output logic [N-1:0] master_1_rdata,
    output logic         master_1_err,
    input  logic         master_2_req,
    input  logic [N-1:0] master_2_addr,
    input  logic         master_2_cmd,
    input  logic [N-1:0] master_2_wdata,
    output logic         master_2_ack,
    output logic [N-1:0] master_2_rdata,
    output logic         master_2_err,
    output logic         slave_req,
    output logic [N-1:0] slave_addr,
    output logic         slave_cmd,
    output logic [N-1:0] slave_wdata,
    input  logic         slave_ack,
    input  logic [N-1:0] slave_rdata,
    output logic [1:0]   grant
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_GNT_M1 = 2'd1;
    localparam logic [1:0] c_GNT_M2 = 2'd2;

    logic [1:0] r_state;
    // 1 = master 2 was served last, so master 1 wins the next tie.
    logic       r_last_m2;
    logic       w_gnt_1;
    logic       w_gnt_2;

`ifdef ARB_TIMEOUT_EN
    localparam int                 c_CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic               r_err_1;
    logic               r_err_2;
`endif

    assign w_gnt_1 = (r_state == c_GNT_M1);
    assign w_gnt_2 = (r_state == c_GNT_M2);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_last_m2 <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            r_cnt     <= '0;
            r_err_1   <= 1'b0;
            r_err_2   <= 1'b0;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
            r_err_1 <= 1'b0;
            r_err_2 <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    // Holding the counter at zero in IDLE clears it on grant entry.
                    r_cnt <= '0;
`endif
                    if (master_1_req && master_2_req) begin
                        r_state <= r_last_m2 ? c_GNT_M1 : c_GNT_M2;
                    end else if (master_1_req) begin
                        r_state <= c_GNT_M1;
                    end else if (master_2_req) begin
                        r_state <= c_GNT_M2;
                    end
                end
                c_GNT_M1: begin
                    // In a grant slave_req mirrors the owner's req, so a
                    // dropped req or an ack both close the grant; ack wins
                    // over timeout expiry on the same edge.
                    if (!master_1_req || slave_ack) begin
                        r_state   <= c_IDLE;
                        r_last_m2 <= 1'b0;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= c_IDLE;
                        r_last_m2 <= 1'b0;
                        r_err_1   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                c_GNT_M2: begin
                    if (!master_2_req || slave_ack) begin
                        r_state   <= c_IDLE;
                        r_last_m2 <= 1'b1;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (r_cnt == c_CNT_LAST) begin
                        r_state   <= c_IDLE;
                        r_last_m2 <= 1'b1;
                        r_err_2   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + c_CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // Slave request channel: owner's inputs, all zero in IDLE.
    assign slave_req   = (w_gnt_1 & master_1_req) | (w_gnt_2 & master_2_req);
    assign slave_addr  = w_gnt_1 ? master_1_addr  : (w_gnt_2 ? master_2_addr  : '0);
    assign slave_cmd   = w_gnt_1 ? master_1_cmd   : (w_gnt_2 ? master_2_cmd   : 1'b0);
    assign slave_wdata = w_gnt_1 ? master_1_wdata : (w_gnt_2 ? master_2_wdata : '0);

    // Responses only reach the owner; slave_ack outside a grant is dropped.
    assign master_1_ack   = w_gnt_1 & slave_req & slave_ack;
    assign master_2_ack   = w_gnt_2 & slave_req & slave_ack;
    assign master_1_rdata = w_gnt_1 ? slave_rdata : '0;
    assign master_2_rdata = w_gnt_2 ? slave_rdata : '0;

    assign grant = {w_gnt_2, w_gnt_1};

`ifdef ARB_TIMEOUT_EN
    assign master_1_err = r_err_1;
    assign master_2_err = r_err_2;
`else
    // No counter in this build: err is constant low whatever TIMEOUT is set to.
    if (TIMEOUT > 0) begin : g_err_tied
        assign master_1_err = 1'b0;
        assign master_2_err = 1'b0;
    end else begin : g_err_tied_any
        assign master_1_err = 1'b0;
        assign master_2_err = 1'b0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_master_arbiter
// Description : Self-checking bench for master_arbiter. A cycle table covers
//               grant, muxing, ack, req-drop and idle-ack cases; hand-written
//               sequences cover round-robin from reset, reset mid-grant and
//               the timeout (ARB_TIMEOUT_EN) or hold-forever behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_master_arbiter;

    localparam int N = 32;

    localparam logic [N-1:0] c_A1 = 32'h1000_0004;
    localparam logic [N-1:0] c_W1 = 32'h1111_1111;
    localparam logic         c_C1 = 1'b0;
    localparam logic [N-1:0] c_A2 = 32'h2000_0008;
    localparam logic [N-1:0] c_W2 = 32'hFFFF_FFFF;
    localparam logic         c_C2 = 1'b1;

    logic         clk = 1'b0;
    logic         rst;
    logic         m1_req, m2_req;
    logic         m1_ack, m2_ack, m1_err, m2_err;
    logic [N-1:0] m1_rdata, m2_rdata;
    logic         s_req, s_cmd, s_ack;
    logic [N-1:0] s_addr, s_wdata, s_rdata;
    logic [1:0]   grant;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    master_arbiter #(.N(N), .TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .master_1_req   (m1_req),
        .master_1_addr  (c_A1),
        .master_1_cmd   (c_C1),
        .master_1_wdata (c_W1),
        .master_1_ack   (m1_ack),
        .master_1_rdata (m1_rdata),
        .master_1_err   (m1_err),
        .master_2_req   (m2_req),
        .master_2_addr  (c_A2),
        .master_2_cmd   (c_C2),
        .master_2_wdata (c_W2),
        .master_2_ack   (m2_ack),
        .master_2_rdata (m2_rdata),
        .master_2_err   (m2_err),
        .slave_req      (s_req),
        .slave_addr     (s_addr),
        .slave_cmd      (s_cmd),
        .slave_wdata    (s_wdata),
        .slave_ack      (s_ack),
        .slave_rdata    (s_rdata),
        .grant          (grant)
    );

    typedef struct {
        logic         rst;
        logic         r1;
        logic         r2;
        logic         sack;
        logic [N-1:0] srd;
        logic [1:0]   g;
        logic         sreq;
        logic         k1;
        logic         k2;
        logic [N-1:0] rd1;
        logic [N-1:0] rd2;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b0; m2_req = 1'b0; s_ack = 1'b0; s_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] eg;
        rst = 1'b1; m1_req = 1'b0; m2_req = 1'b0; s_ack = 1'b0; s_rdata = '0;

        //            rst  r1   r2   sack srd            g      sreq k1   k2   rd1            rd2
        tbl[0]  = '{1'b1,1'b1,1'b1,1'b1,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[1]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[2]  = '{1'b0,1'b1,1'b0,1'b0,32'h77,        2'b01,1'b1,1'b0,1'b0,32'h77,        32'h0};
        tbl[3]  = '{1'b0,1'b1,1'b0,1'b1,32'hCAFE_F00D, 2'b01,1'b1,1'b1,1'b0,32'hCAFE_F00D, 32'h0};
        tbl[4]  = '{1'b0,1'b0,1'b0,1'b1,32'h5A5A,      2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[6]  = '{1'b0,1'b1,1'b1,1'b0,32'h99,        2'b10,1'b1,1'b0,1'b0,32'h0,         32'h99};
        tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,32'h1234_5678, 2'b10,1'b1,1'b0,1'b1,32'h0,         32'h1234_5678};
        tbl[8]  = '{1'b0,1'b1,1'b0,1'b0,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[9]  = '{1'b0,1'b0,1'b1,1'b1,32'h4444,      2'b01,1'b0,1'b0,1'b0,32'h4444,      32'h0};
        tbl[10] = '{1'b0,1'b0,1'b1,1'b0,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};
        tbl[11] = '{1'b0,1'b0,1'b1,1'b1,32'h5555,      2'b10,1'b1,1'b0,1'b1,32'h0,         32'h5555};
        tbl[12] = '{1'b0,1'b0,1'b0,1'b0,32'h0,         2'b00,1'b0,1'b0,1'b0,32'h0,         32'h0};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = tbl[i].rst; m1_req = tbl[i].r1; m2_req = tbl[i].r2;
            s_ack = tbl[i].sack; s_rdata = tbl[i].srd;
            #1;
            check($sformatf("row%0d grant", i), 32'(grant), 32'(tbl[i].g));
            check($sformatf("row%0d slave_req", i), 32'(s_req), 32'(tbl[i].sreq));
            check($sformatf("row%0d ack1", i), 32'(m1_ack), 32'(tbl[i].k1));
            check($sformatf("row%0d ack2", i), 32'(m2_ack), 32'(tbl[i].k2));
            check($sformatf("row%0d rdata1", i), m1_rdata, tbl[i].rd1);
            check($sformatf("row%0d rdata2", i), m2_rdata, tbl[i].rd2);
            check($sformatf("row%0d err", i), 32'({m2_err, m1_err}), 32'h0);
            check($sformatf("row%0d slave_addr", i), s_addr,
                  (tbl[i].g == 2'b01) ? c_A1 : ((tbl[i].g == 2'b10) ? c_A2 : 32'h0));
            check($sformatf("row%0d slave_wdata", i), s_wdata,
                  (tbl[i].g == 2'b01) ? c_W1 : ((tbl[i].g == 2'b10) ? c_W2 : 32'h0));
            check($sformatf("row%0d slave_cmd", i), 32'(s_cmd), (tbl[i].g == 2'b10) ? 32'h1 : 32'h0);
        end

        // Both masters requesting from reset, slave always acking:
        // grants alternate m1, m2, m1, m2 with one IDLE cycle between.
        do_reset();
        m1_req = 1'b1; m2_req = 1'b1; s_ack = 1'b1; s_rdata = 32'hABCD_0123;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            eg = (i % 2 == 0) ? 2'b00 : ((i % 4 == 1) ? 2'b01 : 2'b10);
            check($sformatf("rr%0d grant", i), 32'(grant), 32'(eg));
            check($sformatf("rr%0d ack1", i), 32'(m1_ack), (eg == 2'b01) ? 32'h1 : 32'h0);
            check($sformatf("rr%0d ack2", i), 32'(m2_ack), (eg == 2'b10) ? 32'h1 : 32'h0);
        end

        // Reset during GNT_M2: aborts without ack or err, then m1 wins the tie.
        do_reset();
        m2_req = 1'b1; s_ack = 1'b0;
        @(negedge clk); #1;
        check("rst_mid grant before", 32'(grant), 32'h2);
        @(negedge clk);
        rst = 1'b1; m1_req = 1'b1;
        @(negedge clk); #1;
        check("rst_mid grant", 32'(grant), 32'h0);
        check("rst_mid slave_req", 32'(s_req), 32'h0);
        check("rst_mid ack2", 32'(m2_ack), 32'h0);
        check("rst_mid err2", 32'(m2_err), 32'h0);
        rst = 1'b0;
        @(negedge clk); #1;
        check("rst_mid tie to m1", 32'(grant), 32'h1);

        // Slave never acks with both masters requesting.
        do_reset();
        m1_req = 1'b1; m2_req = 1'b1; s_ack = 1'b0;
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            eg = (i == 0 || i == 5) ? 2'b00 : ((i == 6) ? 2'b10 : 2'b01);
            check($sformatf("to%0d grant", i), 32'(grant), 32'(eg));
            check($sformatf("to%0d err1", i), 32'(m1_err), (i == 5) ? 32'h1 : 32'h0);
            check($sformatf("to%0d ack1", i), 32'(m1_ack), 32'h0);
        end
`else
        for (int i = 0; i < 12; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            check($sformatf("hold%0d grant", i), 32'(grant), (i == 0) ? 32'h0 : 32'h1);
            check($sformatf("hold%0d err1", i), 32'(m1_err), 32'h0);
        end
`endif

        m1_req = 1'b0; m2_req = 1'b0;
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
